// File: rtl/sha3_burst_scheduler.sv
// rtl/sha3_burst_scheduler.sv - shares one burst-mode SHA3-1600 core among several requesters
// Round-robin packs client states into fixed-length bursts, tags each slot, routes results back.
module sha3_burst_scheduler #(
    parameter int REQUESTERS = 4,
    parameter int BURST_LEN  = 14,
    parameter int ID_W       = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [REQUESTERS-1:0]        req_valid,
    input  logic [REQUESTERS*1600-1:0]   req_state,
    output logic [REQUESTERS-1:0]        req_ready,
    input  logic                         core_gimme,
    output logic                         core_sample,
    output logic [1599:0]                core_state,
    input  logic                         core_good,
    input  logic [1599:0]                core_result,
    output logic                         res_valid,
    output logic [ID_W-1:0]              res_id,
    output logic [1599:0]                res_state,
    output logic                         busy,
    output logic                         err_unexpected
);
    localparam int PTR_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam logic [PTR_W-1:0] LAST    = PTR_W'(BURST_LEN - 1);
    localparam logic [ID_W-1:0]  LAST_ID = ID_W'(REQUESTERS - 1);

    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

    state_t           state, state_nx;
    logic [PTR_W-1:0] slot_cnt, slot_cnt_nx;
    logic [PTR_W-1:0] res_cnt;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  gnt_id;
    logic             any_valid;
    logic             slot_en;
    logic             push, pop;
    logic [1599:0]    gnt_state;
    int               rr_idx;

    // tag entry: {used, id}
    logic [ID_W:0]    tag_mem [BURST_LEN];
    logic [ID_W:0]    tag_in, tag_out;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] fifo_cnt;
    logic             fifo_empty;

    // first valid requester at or after the round-robin pointer
    always_comb begin
        any_valid = 1'b0;
        gnt_id    = '0;
        rr_idx    = 0;
        for (int k = 0; k < REQUESTERS; k++) begin
            rr_idx = (int'(rr_ptr) + k) % REQUESTERS;
            if (!any_valid && req_valid[rr_idx]) begin
                any_valid = 1'b1;
                gnt_id    = ID_W'(rr_idx);
            end
        end
    end

    assign gnt_state = req_state[int'(gnt_id)*1600 +: 1600];

    always_comb begin
        state_nx    = state;
        slot_cnt_nx = slot_cnt;
        slot_en     = 1'b0;
        case (state)
            IDLE: begin
                if (core_gimme && any_valid) begin
                    slot_en     = 1'b1;
                    slot_cnt_nx = PTR_W'(1);
                    state_nx    = BURST;
                end
            end
            BURST: begin
                slot_en = 1'b1;
                if (slot_cnt == LAST) begin
                    slot_cnt_nx = '0;
                    state_nx    = DRAIN;
                end else begin
                    slot_cnt_nx = slot_cnt + PTR_W'(1);
                end
            end
            DRAIN: begin
                if (pop && res_cnt == LAST) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign req_ready  = (slot_en && any_valid) ? (REQUESTERS'(1) << gnt_id) : '0;
    assign busy       = (state != IDLE);
    assign push       = slot_en;
    assign tag_in     = {any_valid, any_valid ? gnt_id : {ID_W{1'b0}}};
    assign fifo_empty = (fifo_cnt == '0);
    assign pop        = core_good && !fifo_empty;
    assign tag_out    = tag_mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            slot_cnt <= '0;
            res_cnt  <= '0;
            rr_ptr   <= '0;
        end else begin
            state    <= state_nx;
            slot_cnt <= slot_cnt_nx;
            if (pop) begin
                res_cnt <= (res_cnt == LAST) ? '0 : res_cnt + PTR_W'(1);
            end
            if (slot_en && any_valid) begin
                rr_ptr <= (gnt_id == LAST_ID) ? '0 : gnt_id + ID_W'(1);
            end
        end
    end

    // Tag storage needs no reset: occupancy is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr] <= tag_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_sample    <= 1'b0;
            core_state     <= '0;
            res_valid      <= 1'b0;
            res_id         <= '0;
            res_state      <= '0;
            err_unexpected <= 1'b0;
        end else begin
            core_sample <= slot_en;
            core_state  <= (slot_en && any_valid) ? gnt_state : '0;
            res_valid   <= pop && tag_out[ID_W];
            if (pop) begin
                res_id    <= tag_out[ID_W-1:0];
                res_state <= core_result;
            end
            // stale results (e.g. after a reset mid-operation) have no tag to match
            if (core_good && fifo_empty) begin
                err_unexpected <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sha3_burst_scheduler.sv
// tb/tb_sha3_burst_scheduler.sv - directed self-checking bench for sha3_burst_scheduler
// A behavioural core returns state ^ MASK in slot order; expectations come from hand-written grant tables.
module tb_sha3_burst_scheduler;
    localparam int N = 4;
    localparam int BL = 14;
    localparam logic [1599:0] MASK = {25{64'hDEAD_BEEF_0123_4567}};

    logic            clk, rst;
    logic [N-1:0]    req_valid, req_ready;
    logic [N*1600-1:0] req_state;
    logic            core_gimme, core_sample, core_good;
    logic [1599:0]   core_state, core_result, res_state;
    logic            res_valid, busy, err_unexpected;
    logic [1:0]      res_id;

    int checks = 0;
    int errors = 0;
    int rem [N];
    int seq [N];
    int e [BL];
    int q_used [$];
    int q_id [$];
    logic [1599:0] q_st [$];

    sha3_burst_scheduler #(.REQUESTERS(N), .BURST_LEN(BL), .ID_W(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_state(req_state),
        .req_ready(req_ready), .core_gimme(core_gimme), .core_sample(core_sample),
        .core_state(core_state), .core_good(core_good), .core_result(core_result),
        .res_valid(res_valid), .res_id(res_id), .res_state(res_state),
        .busy(busy), .err_unexpected(err_unexpected)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [1599:0] obs, input logic [1599:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs[127:0], exp[127:0]);
        end
    endtask

    function automatic logic [1599:0] mk_state(input int i, input int s);
        return {8'(i + 1), 1576'b0, 8'(i), 8'(s)};
    endfunction

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = (rem[i] > 0);
            req_state[i*1600 +: 1600] = mk_state(i, seq[i]);
        end
    endtask

    // Caller must already sit on a falling edge; slot 0 is granted there.
    task automatic run_burst();
        logic [1599:0] prev_st;
        logic [N-1:0]  exp_rdy;
        prev_st = '0;
        for (int k = 0; k < BL; k++) begin
            if (k > 0) begin
                @(negedge clk);
                chk("core_sample", 1600'(core_sample), 1600'(1));
                chk("core_state", core_state, prev_st);
            end
            drive_reqs();
            #1;
            exp_rdy = (e[k] >= 0) ? (4'b0001 << e[k]) : 4'b0000;
            chk("req_ready", 1600'(req_ready), 1600'(exp_rdy));
            if (e[k] >= 0) begin
                prev_st = mk_state(e[k], seq[e[k]]);
                seq[e[k]]++;
                rem[e[k]]--;
                q_used.push_back(1);
                q_id.push_back(e[k]);
            end else begin
                prev_st = '0;
                q_used.push_back(0);
                q_id.push_back(0);
            end
            q_st.push_back(prev_st);
        end
        @(negedge clk);
        chk("core_sample_last", 1600'(core_sample), 1600'(1));
        chk("core_state_last", core_state, prev_st);
        drive_reqs();
        #1;
        chk("drain_no_grant", 1600'(req_ready), 1600'(0));
        chk("busy_drain", 1600'(busy), 1600'(1));
    endtask

    task automatic check_res(input int used, input int id, input logic [1599:0] st);
        chk("res_valid", 1600'(res_valid), 1600'(used));
        chk("res_id", 1600'(res_id), 1600'(id));
        chk("res_state", res_state, st ^ MASK);
    endtask

    // Ends on the falling edge after the last result, with the FSM back in IDLE.
    task automatic run_results();
        int used, id;
        logic [1599:0] st;
        used = 0;
        id = 0;
        st = '0;
        for (int k = 0; k < BL; k++) begin
            if (k > 0) begin
                @(negedge clk);
                check_res(used, id, st);
                chk("res_no_grant", 1600'(req_ready), 1600'(0));
            end
            if (k == 1) chk("core_sample_end", 1600'(core_sample), 1600'(0));
            used = q_used.pop_front();
            id = q_id.pop_front();
            st = q_st.pop_front();
            core_good = 1'b1;
            core_result = st ^ MASK;
        end
        @(negedge clk);
        core_good = 1'b0;
        check_res(used, id, st);
        chk("busy_idle", 1600'(busy), 1600'(0));
        chk("no_err", 1600'(err_unexpected), 1600'(0));
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_state = '0;
        core_gimme = 1'b0;
        core_good = 1'b0;
        core_result = '0;
        for (int i = 0; i < N; i++) begin
            rem[i] = 0;
            seq[i] = 0;
        end
        @(negedge clk);
        chk("rst_core_sample", 1600'(core_sample), 1600'(0));
        chk("rst_core_state", core_state, '0);
        chk("rst_res_valid", 1600'(res_valid), 1600'(0));
        chk("rst_res_id", 1600'(res_id), 1600'(0));
        chk("rst_res_state", res_state, '0);
        chk("rst_busy", 1600'(busy), 1600'(0));
        chk("rst_err", 1600'(err_unexpected), 1600'(0));
        rst = 1'b0;

        // clients 0,1,3 from pointer 0: 0,1,3 repeating, pointer wraps 3->0
        @(negedge clk);
        rem = '{1000, 1000, 0, 1000};
        core_gimme = 1'b1;
        for (int k = 0; k < BL; k++) e[k] = (k % 3 == 2) ? 3 : k % 3;
        run_burst();
        run_results();

        // only client 2 (pointer now 2)
        rem = '{0, 0, 1000, 0};
        for (int k = 0; k < BL; k++) e[k] = 2;
        run_burst();
        run_results();

        // three single requests from pointer 3, then bubbles
        rem = '{1, 1, 1, 0};
        for (int k = 0; k < BL; k++) e[k] = (k < 3) ? k : -1;
        run_burst();
        run_results();

        // gimme low holds everything off
        rem = '{1000, 1000, 1000, 1000};
        core_gimme = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive_reqs();
            #1;
            chk("nogimme_ready", 1600'(req_ready), 1600'(0));
            @(negedge clk);
            chk("nogimme_sample", 1600'(core_sample), 1600'(0));
            chk("nogimme_busy", 1600'(busy), 1600'(0));
        end
        core_gimme = 1'b1;
        for (int k = 0; k < BL; k++) e[k] = (3 + k) % 4;
        run_burst();
        run_results();

        // reset at slot 7, then stale core results
        drive_reqs();
        repeat (7) @(negedge clk);
        req_valid = '0;
        rst = 1'b1;
        #1;
        chk("midrst_busy", 1600'(busy), 1600'(0));
        chk("midrst_sample", 1600'(core_sample), 1600'(0));
        chk("midrst_state", core_state, '0);
        chk("midrst_res_valid", 1600'(res_valid), 1600'(0));
        chk("midrst_res_state", res_state, '0);
        @(negedge clk);
        rst = 1'b0;
        core_gimme = 1'b0;
        for (int k = 0; k < BL; k++) begin
            core_good = 1'b1;
            core_result = MASK ^ 1600'(k);
            @(negedge clk);
            chk("stale_res_valid", 1600'(res_valid), 1600'(0));
            chk("stale_err", 1600'(err_unexpected), 1600'(1));
        end
        core_good = 1'b0;
        @(negedge clk);
        chk("err_sticky", 1600'(err_unexpected), 1600'(1));
        rst = 1'b1;
        #1;
        chk("err_cleared", 1600'(err_unexpected), 1600'(0));
        @(negedge clk);
        rst = 1'b0;

        // back-to-back bursts with all clients held valid
        @(negedge clk);
        rem = '{1000, 1000, 1000, 1000};
        core_gimme = 1'b1;
        for (int k = 0; k < BL; k++) e[k] = k % 4;
        run_burst();
        run_results();
        for (int k = 0; k < BL; k++) e[k] = (2 + k) % 4;
        run_burst();
        run_results();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
